// File: rtl/i2c_slave_regbank.sv
// I2C slave register target: multi-byte write/read with an auto-incrementing pointer and a host port.
// SCL/SDA are oversampled on clk; SCL is never driven and SDA is only ever pulled low.
module i2c_slave_regbank #(
    parameter int G_NB_REGS     = 16,
    parameter int G_SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [6:0]                   i_chip_addr,
    input  logic                         i_en,
    input  logic                         i_host_we,
    input  logic [$clog2(G_NB_REGS)-1:0] i_host_addr,
    input  logic [7:0]                   i_host_wdata,
    output logic [7:0]                   o_host_rdata,
    output logic [7:0]                   o_wdata,
    output logic                         o_wdata_valid,
    output logic [$clog2(G_NB_REGS)-1:0] o_reg_ptr,
    output logic [7:0]                   o_rdata,
    output logic                         o_rdata_valid,
    output logic                         o_chip_addr_ok,
    output logic                         o_busy,
    inout  wire                          scl,
    inout  wire                          sda
);
    localparam int PW = $clog2(G_NB_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_IGNORE
    } state_t;

    state_t                   state_q, state_d;
    logic [G_SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
    logic                     sclPrev_q, sdaPrev_q;
    logic [2:0]               bitCnt_q, bitCnt_d;
    logic [6:0]               rxShift_q, rxShift_d;
    logic [7:0]               txByte_q, txByte_d;
    logic                     sdaLow_q, sdaLow_d;
    logic                     phase_q, phase_d;
    logic                     rw_q, rw_d;
    logic [6:0]               addrSel_q, addrSel_d;
    logic                     enSel_q, enSel_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [7:0]               wdata_q, wdata_d;
    logic [7:0]               rdata_q, rdata_d;
    logic                     wvalid_q, wvalid_d;
    logic                     rvalid_q, rvalid_d;
    logic                     addrOk_q, addrOk_d;
    logic                     busy_q, busy_d;
    logic                     bankWe;
    logic [7:0]               regs_q [G_NB_REGS];

    logic       sclS, sdaS, sclRise, sclFall, startDet, stopDet;
    logic [7:0] rxByte;

    // Synchronisers reset to the idle-bus level so reset release never looks like a bus event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[G_SYNC_STAGES-2:0], scl};
            sdaSync_q <= {sdaSync_q[G_SYNC_STAGES-2:0], sda};
            sclPrev_q <= sclSync_q[G_SYNC_STAGES-1];
            sdaPrev_q <= sdaSync_q[G_SYNC_STAGES-1];
        end
    end

    assign sclS     = sclSync_q[G_SYNC_STAGES-1];
    assign sdaS     = sdaSync_q[G_SYNC_STAGES-1];
    assign sclRise  = sclS & ~sclPrev_q;
    assign sclFall  = ~sclS & sclPrev_q;
    assign startDet = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    assign stopDet  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;
    assign rxByte   = {rxShift_q, sdaS};

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        rxShift_d = rxShift_q;
        txByte_d  = txByte_q;
        sdaLow_d  = sdaLow_q;
        phase_d   = phase_q;
        rw_d      = rw_q;
        addrSel_d = addrSel_q;
        enSel_d   = enSel_q;
        ptr_d     = ptr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wvalid_d  = 1'b0;
        rvalid_d  = 1'b0;
        addrOk_d  = addrOk_q;
        busy_d    = busy_q;
        bankWe    = 1'b0;
        if (startDet) begin
            state_d   = S_ADDR;
            bitCnt_d  = 3'd0;
            phase_d   = 1'b0;
            sdaLow_d  = 1'b0;
            busy_d    = 1'b1;
            addrOk_d  = 1'b0;
            addrSel_d = i_chip_addr;
            enSel_d   = i_en;
        end else if (stopDet) begin
            state_d  = S_IDLE;
            phase_d  = 1'b0;
            sdaLow_d = 1'b0;
            busy_d   = 1'b0;
            addrOk_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (sclRise) begin
                        rxShift_d = rxByte[6:0];
                        bitCnt_d  = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            if (state_q == S_ADDR) begin
                                if (enSel_q && (rxByte[7:1] == addrSel_q)) begin
                                    state_d  = S_ADDR_ACK;
                                    addrOk_d = 1'b1;
                                    rw_d     = rxByte[0];
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d   = rxByte[PW-1:0];
                                state_d = S_PTR_ACK;
                            end else begin
                                bankWe   = 1'b1;
                                wdata_d  = rxByte;
                                wvalid_d = 1'b1;
                                ptr_d    = ptr_q + PW'(1);
                                state_d  = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // phase_q marks the ACK low period: first fall pulls SDA, second fall ends the ACK.
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (sclFall) begin
                        if (!phase_q) begin
                            phase_d  = 1'b1;
                            sdaLow_d = 1'b1;
                        end else begin
                            phase_d  = 1'b0;
                            sdaLow_d = 1'b0;
                            bitCnt_d = 3'd0;
                            if ((state_q == S_ADDR_ACK) && rw_q) begin
                                state_d  = S_RDATA;
                                txByte_d = regs_q[ptr_q];
                                sdaLow_d = ~regs_q[ptr_q][7];
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (sclRise) begin
                        bitCnt_d = bitCnt_q + 3'd1;
                    end else if (sclFall) begin
                        if (bitCnt_q == 3'd0) begin
                            sdaLow_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = S_MACK;
                        end else begin
                            sdaLow_d = ~txByte_q[3'd7 - bitCnt_q];
                        end
                    end
                end
                S_MACK: begin
                    if (sclRise && !phase_q) begin
                        rdata_d  = txByte_q;
                        rvalid_d = 1'b1;
                        ptr_d    = ptr_q + PW'(1);
                        if (sdaS) begin
                            state_d = S_IGNORE;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (sclFall && phase_q) begin
                        phase_d  = 1'b0;
                        bitCnt_d = 3'd0;
                        txByte_d = regs_q[ptr_q];
                        sdaLow_d = ~regs_q[ptr_q][7];
                        state_d  = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bitCnt_q  <= '0;
            rxShift_q <= '0;
            txByte_q  <= '0;
            sdaLow_q  <= 1'b0;
            phase_q   <= 1'b0;
            rw_q      <= 1'b0;
            addrSel_q <= '0;
            enSel_q   <= 1'b0;
            ptr_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            addrOk_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            rxShift_q <= rxShift_d;
            txByte_q  <= txByte_d;
            sdaLow_q  <= sdaLow_d;
            phase_q   <= phase_d;
            rw_q      <= rw_d;
            addrSel_q <= addrSel_d;
            enSel_q   <= enSel_d;
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wvalid_q  <= wvalid_d;
            rvalid_q  <= rvalid_d;
            addrOk_q  <= addrOk_d;
            busy_q    <= busy_d;
        end
    end

    // The I2C write is applied after the host write so it wins on a same-cycle collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < G_NB_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            if (i_host_we) begin
                regs_q[i_host_addr] <= i_host_wdata;
            end
            if (bankWe) begin
                regs_q[ptr_q] <= rxByte;
            end
        end
    end

    assign sda            = sdaLow_q ? 1'b0 : 1'bz;
    assign o_host_rdata   = regs_q[i_host_addr];
    assign o_wdata        = wdata_q;
    assign o_wdata_valid  = wvalid_q;
    assign o_reg_ptr      = ptr_q;
    assign o_rdata        = rdata_q;
    assign o_rdata_valid  = rvalid_q;
    assign o_chip_addr_ok = addrOk_q;
    assign o_busy         = busy_q;

endmodule
